ser_deserializer: RTL

// - Downstream stage of the serial link: consumes ser_data/ser_data_val from the serializer.
// - Rebuilds each frame (a contiguous run of valid bits, MSB first) into a left-justified parallel word plus a bit count.
// - Holds the result in a one-entry output buffer with a valid/ready handshake.
// - Flags overflow when the buffer is full, and flags runt frames.

---
 rtl/ser_deserializer.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/ser_deserializer.sv
// Serial-to-parallel deserializer: gathers MSB-first frames of valid bits into a
// left-justified word plus bit count, held in a one-entry valid/ready output buffer.
module ser_deserializer #(
   parameter int unsigned DATA_W  = 16,
   parameter int unsigned MOD_W   = $clog2(DATA_W) + 1,
   parameter int unsigned MIN_LEN = 1
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              ser_data_i,
   input  logic              ser_data_val_i,
   output logic [DATA_W-1:0] data_o,
   output logic [MOD_W-1:0]  data_mod_o,
   output logic              data_val_o,
   input  logic              data_rdy_i,
   output logic              busy_o,
   output logic              ovf_o,
   output logic              runt_o
);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t              state_q, state_d;
   logic [DATA_W-1:0]   shreg_q, shreg_d;
   logic [MOD_W-1:0]    count_q, count_d;

   logic [DATA_W-1:0]   data_d;
   logic [MOD_W-1:0]    mod_d;
   logic                val_d;
   logic                busy_d;
   logic                ovf_d;
   logic                runt_d;

   logic [DATA_W-1:0]   shifted_c;
   logic [DATA_W-1:0]   frame_word_c;
   logic [MOD_W-1:0]    frame_len_c;
   logic                done_c;
   logic                drain_c;
   logic                load_c;

   // State register
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Collect bits, detect frame completion, and steer the output buffer
   always_comb begin
      state_d      = state_q;
      shreg_d      = shreg_q;
      count_d      = count_q;
      data_d       = data_o;
      mod_d        = data_mod_o;
      val_d        = data_val_o;
      ovf_d        = 1'b0;
      runt_d       = 1'b0;
      frame_word_c = '0;
      frame_len_c  = '0;
      done_c       = 1'b0;
      load_c       = 1'b0;
      drain_c      = data_val_o & data_rdy_i;
      shifted_c    = {shreg_q[DATA_W-2:0], ser_data_i};

      case (state_q)
         IDLE: begin
            if (ser_data_val_i) begin
               shreg_d = shifted_c;
               count_d = MOD_W'(1);
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            if (ser_data_val_i) begin
               shreg_d = shifted_c;
               // Last bit of a full-width frame completes it on the same edge
               if (count_q == MOD_W'(DATA_W - 1)) begin
                  done_c       = 1'b1;
                  frame_word_c = shifted_c;
                  frame_len_c  = MOD_W'(DATA_W);
                  count_d      = '0;
                  state_d      = IDLE;
               end else begin
                  count_d = count_q + MOD_W'(1);
               end
            end else begin
               // Left-justify: stale bits above the frame are shifted out
               done_c       = 1'b1;
               frame_word_c = shreg_q << (MOD_W'(DATA_W) - count_q);
               frame_len_c  = count_q;
               count_d      = '0;
               state_d      = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            count_d = '0;
         end
      endcase

      // Runt takes priority over overflow; a draining buffer accepts a new frame
      if (done_c) begin
         if (frame_len_c < MOD_W'(MIN_LEN)) begin
            runt_d = 1'b1;
         end else if (data_val_o && !data_rdy_i) begin
            ovf_d = 1'b1;
         end else begin
            load_c = 1'b1;
         end
      end

      if (load_c) begin
         data_d = frame_word_c;
         mod_d  = frame_len_c;
         val_d  = 1'b1;
      end else if (drain_c) begin
         val_d = 1'b0;
      end

      busy_d = (count_d != '0);
   end

   // Datapath and output registers
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         shreg_q    <= '0;
         count_q    <= '0;
         data_o     <= '0;
         data_mod_o <= '0;
         data_val_o <= 1'b0;
         busy_o     <= 1'b0;
         ovf_o      <= 1'b0;
         runt_o     <= 1'b0;
      end else begin
         shreg_q    <= shreg_d;
         count_q    <= count_d;
         data_o     <= data_d;
         data_mod_o <= mod_d;
         data_val_o <= val_d;
         busy_o     <= busy_d;
         ovf_o      <= ovf_d;
         runt_o     <= runt_d;
      end
   end

endmodule
